// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 mux select arbiter.
//   NUM_CH         number of arbitrated channels (A..D)
//   CH_A..CH_D     channel indices, also the mux select code for that channel
//   IDLE/GRANT     arbiter FSM state codes
//   ch_to_sel()    channel index -> {sel1, sel2}
package mux_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // The mux select code is the binary channel index; sel1 is the MSB.
    function automatic logic [1:0] ch_to_sel(input logic [1:0] idx);
        logic [1:0] sel;
        sel[1] = idx[1];
        sel[0] = idx[0];
        return sel;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   channel requests, bit0 = A
//   ptr   last granted channel; the search starts just after it
//   pick  first requesting channel among ptr+1, ptr+2, ptr+3, ptr+4 (mod 4)
//   any   at least one request is present (pick is meaningless otherwise)
module rr_pick
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        ptr,
    output logic [1:0]        pick,
    output logic              any
);

    logic [1:0]        cand [NUM_CH];
    logic [NUM_CH-1:0] hit;

    // cand[gi] is the channel visited at search step gi; the last step
    // (gi = NUM_CH-1) wraps back to ptr itself, so the current owner is
    // only chosen again when nobody else is asking.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand[gi] = ptr + 2'(gi + 1);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Walk from the lowest priority upward so the earliest hit wins.
    always_comb begin
        pick = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pick = cand[i];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux stage.
// Grants one of four requesting channels, holds the grant for DWELL
// accepted transfers (out_ready=1 cycles) or until the owner drops its
// request, then rotates without an idle bubble when others are waiting.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        channel requests, bit0=A .. bit3=D
//   out_ready  downstream accepted the muxed sample this cycle
//   sel1/sel2  registered mux select (MSB/LSB) of the granted channel
//   grant      registered one-hot grant, 0 when idle
//   sel_valid  grant/select are valid
//   busy       arbiter is in the GRANT state
module mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              out_ready,
    output logic              sel1,
    output logic              sel2,
    output logic [NUM_CH-1:0] grant,
    output logic              sel_valid,
    output logic              busy
);

    logic [0:0]        state_reg, state_next;
    logic [1:0]        ptr_reg, ptr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [NUM_CH-1:0] grant_reg, grant_next;
    logic [1:0]        sel_reg, sel_next;
    logic              valid_reg, valid_next;
    logic              busy_reg, busy_next;

    logic [1:0]        pick;
    logic              any;
    logic [NUM_CH-1:0] pick_onehot;
    logic              cnt_last;
    logic              release_now;

    rr_pick u_rr_pick (
        .req  (req),
        .ptr  (ptr_reg),
        .pick (pick),
        .any  (any)
    );

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick == 2'(gi));
        end
    endgenerate

    // ptr_reg always holds the current owner while in GRANT, so it doubles
    // as the index of the granted request bit.
    assign cnt_last    = (cnt_reg == CNT_W'(DWELL - 1));
    assign release_now = !req[ptr_reg] || (out_ready && cnt_last);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        grant_next = grant_reg;
        sel_next   = sel_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;

        if (state_reg == IDLE) begin
            if (any) begin
                state_next = GRANT;
                ptr_next   = pick;
                cnt_next   = '0;
                grant_next = pick_onehot;
                sel_next   = ch_to_sel(pick);
                valid_next = 1'b1;
                busy_next  = 1'b1;
            end
        end else begin
            if (release_now) begin
                if (any) begin
                    // Back-to-back regrant; may land on the same channel,
                    // in which case only the dwell count restarts.
                    ptr_next   = pick;
                    cnt_next   = '0;
                    grant_next = pick_onehot;
                    sel_next   = ch_to_sel(pick);
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    grant_next = '0;
                    sel_next   = '0;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                end
            end else if (out_ready) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= CH_D;
            cnt_reg   <= '0;
            grant_reg <= '0;
            sel_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
        end
    end

    assign sel1      = sel_reg[1];
    assign sel2      = sel_reg[0];
    assign grant     = grant_reg;
    assign sel_valid = valid_reg;
    assign busy      = busy_reg;

endmodule
